// File: rtl/mmss_set_ctrl_if.sv
// rtl/mmss_set_ctrl_if.sv - button inputs and display outputs of the MM:SS run/set controller
interface mmss_set_ctrl_if;
    logic       btn_mode;
    logic       btn_inc;
    logic [2:0] min1;
    logic [3:0] min0;
    logic [2:0] sec1;
    logic [3:0] sec0;
    logic [3:0] blank;
    logic       colon;
    logic       running;
    logic       sec_pulse;

    modport master (
        output btn_mode, btn_inc,
        input  min1, min0, sec1, sec0, blank, colon, running, sec_pulse
    );

    modport slave (
        input  btn_mode, btn_inc,
        output min1, min0, sec1, sec0, blank, colon, running, sec_pulse
    );
endinterface

// File: rtl/mmss_set_ctrl.sv
// rtl/mmss_set_ctrl.sv - MM:SS time digits, 1 Hz prescaler and run/set mode FSM
// Optional build macro MMSS_AUTO_REPEAT_EN adds auto-repeat for a held increment button.
module mmss_set_ctrl #(
    parameter int TICK_DIV   = 50000000,
    parameter int REPEAT_DIV = 12500000
) (
    input  logic           clk,
    input  logic           rst,
    mmss_set_ctrl_if.slave bus
);
    localparam int PW   = $clog2(TICK_DIV);
    localparam int HALF = TICK_DIV / 2;
    localparam logic [PW-1:0] PRE_MAX  = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PRE_HALF = PW'(HALF);

    localparam logic [2:0] ST_RUN = 3'd0;
    localparam logic [2:0] ST_M1  = 3'd1;
    localparam logic [2:0] ST_M0  = 3'd2;
    localparam logic [2:0] ST_S1  = 3'd3;
    localparam logic [2:0] ST_S0  = 3'd4;

    if (TICK_DIV < 4 || (TICK_DIV % 2) != 0 || REPEAT_DIV < 1) begin : g_param_check
        $error("mmss_set_ctrl: TICK_DIV must be even and >= 4, REPEAT_DIV must be >= 1");
    end

    logic [2:0]    st;
    logic [PW-1:0] pre;
    logic [2:0]    min1_q;
    logic [3:0]    min0_q;
    logic [2:0]    sec1_q;
    logic [3:0]    sec0_q;
    logic          mode_q;
    logic          inc_q;
    logic          sec_pulse_q;

    logic mode_press;
    logic inc_press;
    logic inc_fire;
    logic in_set;
    logic pre_wrap;

    assign mode_press = bus.btn_mode & ~mode_q;
    assign inc_press  = bus.btn_inc & ~inc_q;
    assign in_set     = (st != ST_RUN);
    assign pre_wrap   = (pre == PRE_MAX);

`ifdef MMSS_AUTO_REPEAT_EN
    localparam int RMAX = (HALF > REPEAT_DIV) ? HALF : REPEAT_DIV;
    localparam int RW   = $clog2(RMAX + 1);

    logic [RW-1:0] rep_cnt;
    logic [RW-1:0] rep_k;
    logic          rep_armed;
    logic          held;
    logic          rep_fire;

    // First repeat after HALF held cycles, then every REPEAT_DIV cycles.
    assign held     = in_set & bus.btn_inc & inc_q & ~mode_press;
    assign rep_k    = rep_cnt + RW'(1);
    assign rep_fire = held & (rep_armed ? (rep_k == RW'(REPEAT_DIV)) : (rep_k == RW'(HALF)));
    assign inc_fire = in_set & ~mode_press & (inc_press | rep_fire);

    always_ff @(posedge clk) begin
        if (rst || !held) begin
            rep_cnt   <= '0;
            rep_armed <= 1'b0;
        end else if (rep_fire) begin
            rep_cnt   <= '0;
            rep_armed <= 1'b1;
        end else begin
            rep_cnt   <= rep_k;
        end
    end
`else
    assign inc_fire = in_set & ~mode_press & inc_press;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            st          <= ST_RUN;
            pre         <= '0;
            min1_q      <= 3'd0;
            min0_q      <= 4'd0;
            sec1_q      <= 3'd0;
            sec0_q      <= 4'd0;
            mode_q      <= 1'b0;
            inc_q       <= 1'b0;
            sec_pulse_q <= 1'b0;
        end else begin
            mode_q      <= bus.btn_mode;
            inc_q       <= bus.btn_inc;
            sec_pulse_q <= 1'b0;
            pre         <= pre_wrap ? '0 : pre + PW'(1);

            if (st == ST_RUN) begin
                if (pre_wrap) begin
                    sec_pulse_q <= 1'b1;
                    if (sec0_q == 4'd9) begin
                        sec0_q <= 4'd0;
                        if (sec1_q == 3'd5) begin
                            sec1_q <= 3'd0;
                            if (min0_q == 4'd9) begin
                                min0_q <= 4'd0;
                                min1_q <= (min1_q == 3'd5) ? 3'd0 : min1_q + 3'd1;
                            end else begin
                                min0_q <= min0_q + 4'd1;
                            end
                        end else begin
                            sec1_q <= sec1_q + 3'd1;
                        end
                    end else begin
                        sec0_q <= sec0_q + 4'd1;
                    end
                end
                if (mode_press) begin
                    st <= ST_M1;
                end
            end else if (mode_press) begin
                case (st)
                    ST_M1:   st <= ST_M0;
                    ST_M0:   st <= ST_S1;
                    ST_S1:   st <= ST_S0;
                    default: st <= ST_RUN;
                endcase
                // A fresh full second starts when editing finishes.
                if (st == ST_S0) begin
                    pre <= '0;
                end
            end else if (inc_fire) begin
                pre <= '0;
                case (st)
                    ST_M1:   min1_q <= (min1_q == 3'd5) ? 3'd0 : min1_q + 3'd1;
                    ST_M0:   min0_q <= (min0_q == 4'd9) ? 4'd0 : min0_q + 4'd1;
                    ST_S1:   sec1_q <= (sec1_q == 3'd5) ? 3'd0 : sec1_q + 3'd1;
                    ST_S0:   sec0_q <= (sec0_q == 4'd9) ? 4'd0 : sec0_q + 4'd1;
                    default: ;
                endcase
            end
        end
    end

    logic blink_off;
    assign blink_off = (pre >= PRE_HALF);

    always_comb begin
        bus.blank = 4'b0000;
        case (st)
            ST_M1:   bus.blank[3] = blink_off;
            ST_M0:   bus.blank[2] = blink_off;
            ST_S1:   bus.blank[1] = blink_off;
            ST_S0:   bus.blank[0] = blink_off;
            default: ;
        endcase
    end

    assign bus.colon     = in_set ? 1'b1 : ~blink_off;
    assign bus.running   = (st == ST_RUN);
    assign bus.sec_pulse = sec_pulse_q;
    assign bus.min1      = min1_q;
    assign bus.min0      = min0_q;
    assign bus.sec1      = sec1_q;
    assign bus.sec0      = sec0_q;
endmodule
